// File: rtl/alu_wide_seq_pkg.sv
// Shared GB80 definitions: F flag bit positions, 8-bit alu opcodes, 16-bit op codes
// and the sequencer state encoding.
package alu_wide_seq_pkg;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_CP  = 3'd7;

    typedef enum logic [1:0] {
        WOP_ADD16 = 2'd0,
        WOP_INC16 = 2'd1,
        WOP_DEC16 = 2'd2,
        WOP_ADDSP = 2'd3
    } wop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_wide_flags.sv
// Combinational merge of the F sampled at accept with the LO/HI pass H/C bits
// into the GB80 F layout returned with a wide result.
module alu_wide_flags
    import alu_wide_seq_pkg::*;
(
    input  wop_e       i_op,
    input  logic [3:0] i_f_smp,
    input  logic       i_lo_h,
    input  logic       i_lo_c,
    input  logic       i_hi_h,
    input  logic       i_hi_c,
    output logic [7:0] o_flags
);

    // i_f_smp holds F[7:4] (Z N H C); low nibble of F is always zero
    always_comb begin
        o_flags = 8'h00;
        case (i_op)
            WOP_ADD16: o_flags = {i_f_smp[3], 1'b0, i_hi_h, i_hi_c, 4'h0};
            WOP_INC16,
            WOP_DEC16: o_flags = {i_f_smp, 4'h0};
            WOP_ADDSP: o_flags = {2'b00, i_lo_h, i_lo_c, 4'h0};
            default:   o_flags = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_wide_seq.sv
// Two-pass 16-bit sequencer: drives the 8-bit alu with the low byte, then the high
// byte with carry, and presents the wide result plus merged F until consumed.
module alu_wide_seq
    import alu_wide_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [1:0]                i_req_op,
    input  logic [2*DATA_WIDTH-1:0]   i_op_a,
    input  logic [2*DATA_WIDTH-1:0]   i_op_b,
    input  logic [7:0]                i_flags,
    output logic [DATA_WIDTH-1:0]     o_alu_a,
    output logic [DATA_WIDTH-1:0]     o_alu_b,
    output logic [OPCODE_WIDTH-1:0]   o_alu_op,
    output logic                      o_alu_cin,
    input  logic [DATA_WIDTH-1:0]     i_alu_data,
    input  logic [7:0]                i_alu_flags,
    output logic                      o_res_valid,
    input  logic                      i_res_ready,
    output logic [2*DATA_WIDTH-1:0]   o_res_data,
    output logic [7:0]                o_res_flags,
    input  logic                      i_flush
);

    localparam int W = DATA_WIDTH;

    seq_state_e state_q, state_d;
    wop_e op_q, op_d;
    logic [W-1:0] a_hi_q, a_hi_d, b_hi_q, b_hi_d, lo_res_q, lo_res_d;
    logic [3:0] f_q, f_d;
    logic lo_h_q, lo_h_d, lo_c_q, lo_c_d;
    logic req_ready_q, req_ready_d, res_valid_q, res_valid_d;
    logic [2*W-1:0] res_data_q, res_data_d;
    logic [7:0] res_flags_q, res_flags_d;
    logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPCODE_WIDTH-1:0] alu_op_q, alu_op_d;
    logic alu_cin_q, alu_cin_d;
    logic [7:0] merged_flags;
    logic unused_bits;

    assign unused_bits = ^{i_flags[3:0], i_alu_flags[FLAG_Z], i_alu_flags[FLAG_N], i_alu_flags[3:0]};

    alu_wide_flags u_flags (
        .i_op    (op_q),
        .i_f_smp (f_q),
        .i_lo_h  (lo_h_q),
        .i_lo_c  (lo_c_q),
        .i_hi_h  (i_alu_flags[FLAG_H]),
        .i_hi_c  (i_alu_flags[FLAG_C]),
        .o_flags (merged_flags)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        f_d         = f_q;
        lo_res_d    = lo_res_q;
        lo_h_d      = lo_h_q;
        lo_c_d      = lo_c_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_op_d    = '0;
        alu_cin_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (i_req_valid && req_ready_q) begin
                state_d = ST_LO;
                op_d    = wop_e'(i_req_op);
                a_hi_d  = i_op_a[2*W-1:W];
                f_d     = i_flags[7:4];
                alu_a_d = i_op_a[W-1:0];
                // alu drive is registered, so the LO-pass operands are loaded here
                case (wop_e'(i_req_op))
                    WOP_ADD16: begin
                        alu_b_d  = i_op_b[W-1:0];
                        b_hi_d   = i_op_b[2*W-1:W];
                        alu_op_d = OPCODE_WIDTH'(ALU_ADD);
                    end
                    WOP_INC16: begin
                        alu_b_d  = W'(1);
                        b_hi_d   = '0;
                        alu_op_d = OPCODE_WIDTH'(ALU_ADD);
                    end
                    WOP_DEC16: begin
                        alu_b_d  = W'(1);
                        b_hi_d   = '0;
                        alu_op_d = OPCODE_WIDTH'(ALU_SUB);
                    end
                    default: begin
                        alu_b_d  = i_op_b[W-1:0];
                        b_hi_d   = {W{i_op_b[W-1]}};
                        alu_op_d = OPCODE_WIDTH'(ALU_ADD);
                    end
                endcase
            end
            ST_LO: begin
                state_d   = ST_HI;
                lo_res_d  = i_alu_data;
                lo_h_d    = i_alu_flags[FLAG_H];
                lo_c_d    = i_alu_flags[FLAG_C];
                alu_a_d   = a_hi_q;
                alu_b_d   = b_hi_q;
                alu_op_d  = (op_q == WOP_DEC16) ? OPCODE_WIDTH'(ALU_SBC) : OPCODE_WIDTH'(ALU_ADC);
                alu_cin_d = i_alu_flags[FLAG_C];
            end
            ST_HI: begin
                state_d     = ST_DONE;
                res_data_d  = {i_alu_data, lo_res_q};
                res_flags_d = merged_flags;
            end
            default: if (i_res_ready) begin
                state_d     = ST_IDLE;
                res_data_d  = '0;
                res_flags_d = '0;
            end
        endcase
        if (i_flush) begin
            state_d     = ST_IDLE;
            alu_a_d     = '0;
            alu_b_d     = '0;
            alu_op_d    = '0;
            alu_cin_d   = 1'b0;
            res_data_d  = '0;
            res_flags_d = '0;
        end
        req_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            op_q        <= WOP_ADD16;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            f_q         <= '0;
            lo_res_q    <= '0;
            lo_h_q      <= 1'b0;
            lo_c_q      <= 1'b0;
            req_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            f_q         <= f_d;
            lo_res_q    <= lo_res_d;
            lo_h_q      <= lo_h_d;
            lo_c_q      <= lo_c_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_cin_q   <= alu_cin_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_res_valid = res_valid_q;
    assign o_res_data  = res_data_q;
    assign o_res_flags = res_flags_q;
    assign o_alu_a     = alu_a_q;
    assign o_alu_b     = alu_b_q;
    assign o_alu_op    = alu_op_q;
    assign o_alu_cin   = alu_cin_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq paired with a behavioural 8-bit alu; results are compared
// against a whole-word 16-bit reference model.
module tb_alu_wide_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [1:0]  i_req_op = 2'd0;
    logic [15:0] i_op_a = 16'h0, i_op_b = 16'h0;
    logic [7:0]  i_flags = 8'h0;
    logic [7:0]  o_alu_a, o_alu_b;
    logic [2:0]  o_alu_op;
    logic        o_alu_cin;
    logic [7:0]  alu_data, alu_flags;
    logic        o_res_valid;
    logic        i_res_ready = 1'b0;
    logic [15:0] o_res_data;
    logic [7:0]  o_res_flags;
    logic        i_flush = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_wide_seq #(.DATA_WIDTH(8), .OPCODE_WIDTH(3)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
        .i_op_a(i_op_a), .i_op_b(i_op_b), .i_flags(i_flags),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_alu_cin(o_alu_cin),
        .i_alu_data(alu_data), .i_alu_flags(alu_flags),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_data(o_res_data), .o_res_flags(o_res_flags), .i_flush(i_flush)
    );

    // Stand-in for the real 8-bit alu (ADD/ADC/SUB/SBC only)
    int ua, ub, ci, s;
    always_comb begin
        ua = int'(o_alu_a);
        ub = int'(o_alu_b);
        ci = (o_alu_op == 3'd1 || o_alu_op == 3'd3) ? int'(o_alu_cin) : 0;
        s = 0;
        alu_data = 8'h00;
        alu_flags = 8'h00;
        if (o_alu_op == 3'd0 || o_alu_op == 3'd1) begin
            s = ua + ub + ci;
            alu_data = s[7:0];
            alu_flags[5] = ((ua & 15) + (ub & 15) + ci) > 15;
            alu_flags[4] = s > 255;
        end else if (o_alu_op == 3'd2 || o_alu_op == 3'd3) begin
            s = ua - ub - ci;
            alu_data = s[7:0];
            alu_flags[6] = 1'b1;
            alu_flags[5] = (ua & 15) < ((ub & 15) + ci);
            alu_flags[4] = ua < (ub + ci);
        end
        alu_flags[7] = (alu_data == 8'h00);
    end

    // Whole-word reference: returns {flags, data}
    function automatic logic [23:0] model(input logic [1:0] op, input logic [15:0] a, b,
                                          input logic [7:0] f);
        int ia, ib, e, sx, r;
        logic h, c;
        ia = int'(a); ib = int'(b); e = int'(b[7:0]);
        case (op)
            2'd0: begin
                r = (ia + ib) & 'hFFFF;
                h = ((ia & 'hFFF) + (ib & 'hFFF)) > 'hFFF;
                c = (ia + ib) > 'hFFFF;
                return {f[7], 1'b0, h, c, 4'h0, r[15:0]};
            end
            2'd1: begin r = (ia + 1) & 'hFFFF; return {f[7:4], 4'h0, r[15:0]}; end
            2'd2: begin r = (ia + 'hFFFF) & 'hFFFF; return {f[7:4], 4'h0, r[15:0]}; end
            default: begin
                sx = (e >= 128) ? e - 256 : e;
                r = (ia + sx) & 'hFFFF;
                h = ((ia & 'hF) + (e & 'hF)) > 'hF;
                c = ((ia & 'hFF) + e) > 'hFF;
                return {2'b00, h, c, 4'h0, r[15:0]};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, b, input logic [7:0] f,
                          input int hold, input string tag);
        logic [23:0] exp;
        int n;
        exp = model(op, a, b, f);
        n = 0;
        while (o_req_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check({tag, "_ready"}, 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1; i_req_op = op; i_op_a = a; i_op_b = b; i_flags = f;
        @(negedge clk);
        i_req_valid = 1'b0; i_op_a = 16'($urandom); i_op_b = 16'($urandom); i_flags = 8'($urandom);
        n = 1;
        while (o_res_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_data"}, 32'(o_res_data), 32'(exp[15:0]));
        check({tag, "_flags"}, 32'(o_res_flags), 32'(exp[23:16]));
        check({tag, "_busy"}, 32'(o_req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {o_res_valid, o_req_ready, o_res_flags, o_res_data},
                  {1'b1, 1'b0, exp[23:16], exp[15:0]});
        end
        i_res_ready = 1'b1;
        @(negedge clk);
        i_res_ready = 1'b0;
        check({tag, "_release"}, {o_res_valid, o_req_ready}, 32'b01);
    endtask

    initial begin
        logic [1:0] rop;
        // reset state
        @(negedge clk);
        check("rst_outputs", {o_req_ready, o_res_valid, o_alu_a, o_alu_b, o_alu_op, o_alu_cin},
              32'd0);
        check("rst_res", {o_res_data, o_res_flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(o_req_ready), 32'd1);

        run_op(2'd0, 16'h0FFF, 16'h0001, 8'h80, 0, "add16_h");
        run_op(2'd0, 16'hFFFF, 16'h0001, 8'h00, 0, "add16_wrap");
        run_op(2'd3, 16'hFFF8, 16'h0008, 8'hF0, 0, "addsp_pos");
        run_op(2'd3, 16'h0001, 16'h00FE, 8'hF0, 0, "addsp_neg");
        run_op(2'd2, 16'h0000, 16'h0000, 8'hF0, 0, "dec16_wrap");
        run_op(2'd1, 16'h00FF, 16'h0000, 8'h00, 0, "inc16_carry");
        run_op(2'd1, 16'hFFFF, 16'h0000, 8'h50, 0, "inc16_wrap");
        run_op(2'd0, 16'h8000, 16'h8000, 8'h00, 3, "add16_hold");

        // flush with a request pending in IDLE must not accept
        i_req_valid = 1'b1; i_req_op = 2'd0; i_op_a = 16'h3377; i_op_b = 16'h1111; i_flush = 1'b1;
        @(negedge clk);
        i_req_valid = 1'b0; i_flush = 1'b0;
        check("flush_idle_noaccept", {o_req_ready, o_alu_a}, {1'b1, 8'h00});

        // reset pulse during HI
        i_req_valid = 1'b1; i_req_op = 2'd0; i_op_a = 16'h5555; i_op_b = 16'h2222; i_flags = 8'h80;
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        check("hi_drive_before_rst", 32'(o_alu_a), 32'h55);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {o_req_ready, o_res_valid, o_alu_a, o_alu_b, o_alu_op, o_alu_cin},
              32'd0);
        check("rst_mid_res", {o_res_data, o_res_flags}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_result", 32'(o_res_valid), 32'd0);
        end

        // flush during LO
        i_req_valid = 1'b1; i_req_op = 2'd0; i_op_a = 16'h5555; i_op_b = 16'h2222;
        @(negedge clk);
        i_req_valid = 1'b0; i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        check("flush_lo_idle", {o_req_ready, o_alu_a, o_alu_op}, {1'b1, 8'h00, 3'd0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("flush_no_result", 32'(o_res_valid), 32'd0);
        end
        run_op(2'd0, 16'h1234, 16'h1111, 8'h00, 0, "add16_after_abort");

        // randomized ops
        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom_range(0, 3));
            run_op(rop, 16'($urandom), 16'($urandom), {4'($urandom), 4'h0},
                   int'($urandom_range(0, 2)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
